// File: rtl/slave_splitter_pkg.sv
// Shared types and helpers for the 64-to-2x32 sample splitter.
// Phasing is enabled by defining SPLITTER_GAP_EN.
package slave_splitter_pkg;

  localparam int SAMPLE_W = 64;
  localparam int HALF_W   = 32;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [HALF_W-1:0]   half_t;

  typedef enum logic {
    PH_ACTIVE = 1'b0,
    PH_GAP    = 1'b1
  } phase_e;

  function automatic half_t hi(input sample_t s);
    return s[SAMPLE_W-1:HALF_W];
  endfunction

  function automatic half_t lo(input sample_t s);
    return s[HALF_W-1:0];
  endfunction

endpackage

// File: rtl/splitter_fifo.sv
// Circular sample buffer with registered pointers and occupancy count.
// Read data is the word at the read pointer, available before the pop edge.
module splitter_fifo
  import slave_splitter_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  sample_t                  data_i,
  input  logic                     pop_i,
  output sample_t                  rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  sample_t       mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)
      count_d = count_q + CW'(1);
    else if (do_pop && !do_push)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/slave_splitter.sv
// Buffers 64-bit samples and emits them as two 32-bit halves.
// SPLITTER_GAP_EN enables the periodic active/gap output phase.
module slave_splitter
  import slave_splitter_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int ACTIVE_LEN = 512,
  parameter int GAP_LEN    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic [63:0] sample_in,
  output logic        slave_ready,
  output logic [31:0] port1_data,
  output logic        port1_valid,
  output logic [31:0] port2_data,
  output logic        port2_valid,
  output logic [63:0] dbg_mem_data,
  output logic [31:0] dbg_sample_idx,
  output logic        dbg_active_phase
);

  sample_t               rd_data;
  logic                  full;
  logic                  empty;
  logic [$clog2(DEPTH):0] unused_count;
  logic                  active;
  logic                  push;
  logic                  pop;

  half_t   p1_q, p1_d;
  half_t   p2_q, p2_d;
  sample_t mem_q, mem_d;
  logic    vld_q, vld_d;
  logic [31:0] idx_q, idx_d;

  assign slave_ready = rst_n && !full;
  assign push        = sample_valid && slave_ready;
  assign pop         = active && !empty;

  splitter_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .push_i    (push),
    .data_i    (sample_in),
    .pop_i     (pop),
    .rd_data_o (rd_data),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (unused_count)
  );

`ifdef SPLITTER_GAP_EN
  phase_e      phase_q, phase_d;
  logic [31:0] ph_cnt_q, ph_cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q  <= PH_ACTIVE;
      ph_cnt_q <= '0;
    end else begin
      phase_q  <= phase_d;
      ph_cnt_q <= ph_cnt_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    ph_cnt_d = ph_cnt_q + 32'd1;
    unique case (phase_q)
      PH_ACTIVE: begin
        if (ph_cnt_q == 32'(ACTIVE_LEN - 1)) begin
          phase_d  = PH_GAP;
          ph_cnt_d = '0;
        end
      end
      PH_GAP: begin
        if (ph_cnt_q == 32'(GAP_LEN - 1)) begin
          phase_d  = PH_ACTIVE;
          ph_cnt_d = '0;
        end
      end
      default: begin
        phase_d  = PH_ACTIVE;
        ph_cnt_d = '0;
      end
    endcase
  end

  assign active = (phase_q == PH_ACTIVE);
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(ACTIVE_LEN), 32'(GAP_LEN)};
  assign active     = 1'b1;
`endif

  always_comb begin
    p1_d  = p1_q;
    p2_d  = p2_q;
    mem_d = mem_q;
    vld_d = 1'b0;
    idx_d = idx_q;
    if (pop) begin
      p1_d  = hi(rd_data);
      p2_d  = lo(rd_data);
      mem_d = rd_data;
      vld_d = 1'b1;
      idx_d = idx_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1_q  <= '0;
      p2_q  <= '0;
      mem_q <= '0;
      vld_q <= 1'b0;
      idx_q <= '0;
    end else begin
      p1_q  <= p1_d;
      p2_q  <= p2_d;
      mem_q <= mem_d;
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end

  assign port1_data       = p1_q;
  assign port2_data       = p2_q;
  assign port1_valid      = vld_q;
  assign port2_valid      = vld_q;
  assign dbg_mem_data     = mem_q;
  assign dbg_sample_idx   = idx_q;
  assign dbg_active_phase = active;

endmodule

// File: tb/tb_slave_splitter.sv
// Scoreboard bench for slave_splitter; gap checks follow SPLITTER_GAP_EN.
module tb_slave_splitter;

  localparam int DEPTH = 16;
  localparam int ACT   = 512;
  localparam int GAP   = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [63:0] sample_in = '0;
  logic        slave_ready;
  logic [31:0] port1_data;
  logic        port1_valid;
  logic [31:0] port2_data;
  logic        port2_valid;
  logic [63:0] dbg_mem_data;
  logic [31:0] dbg_sample_idx;
  logic        dbg_active_phase;

  always #5 clk = ~clk;

  slave_splitter #(
    .DEPTH      (DEPTH),
    .ACTIVE_LEN (ACT),
    .GAP_LEN    (GAP)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sample_valid     (sample_valid),
    .sample_in        (sample_in),
    .slave_ready      (slave_ready),
    .port1_data       (port1_data),
    .port1_valid      (port1_valid),
    .port2_data       (port2_data),
    .port2_valid      (port2_valid),
    .dbg_mem_data     (dbg_mem_data),
    .dbg_sample_idx   (dbg_sample_idx),
    .dbg_active_phase (dbg_active_phase)
  );

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: prev_* describe the state seen by the edge just passed.
  logic        prev_rst = 1'b0;
  logic        prev_act = 1'b1;
  int          prev_size = 0;
  logic        m_act = 1'b1;
  int          m_cnt = 0;
  logic [31:0] m_idx = '0;
  logic        exp_v;
  logic [63:0] e;

  always @(negedge clk) begin
    exp_v = prev_rst && prev_act && (prev_size > 0);
    chk("valid", port1_valid, exp_v);
    chk("valid_pair", port2_valid, port1_valid);
    if (!prev_rst) begin
      m_idx = '0;
      m_act = 1'b1;
      m_cnt = 0;
      chk("rst_p1", port1_data, 0);
      chk("rst_p2", port2_data, 0);
      chk("rst_mem", dbg_mem_data, 0);
    end else begin
      if (exp_v) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          m_idx = m_idx + 32'd1;
          chk("p1_data", port1_data, e[63:32]);
          chk("p2_data", port2_data, e[31:0]);
          chk("mem_data", dbg_mem_data, e);
        end
      end
`ifdef SPLITTER_GAP_EN
      m_cnt = m_cnt + 1;
      if (m_act && m_cnt == ACT) begin
        m_act = 1'b0;
        m_cnt = 0;
      end else if (!m_act && m_cnt == GAP) begin
        m_act = 1'b1;
        m_cnt = 0;
      end
`endif
    end
    chk("sample_idx", dbg_sample_idx, m_idx);
    chk("phase", dbg_active_phase, m_act);
    prev_act  = m_act;
    prev_size = exp_q.size();
    prev_rst  = rst_n;
  end

  int n_acc = 0;

  // Called at posedge+1; records the sample if the next edge accepts it.
  task automatic cyc(input logic v, input logic [63:0] d);
    logic acc;
    sample_valid = v;
    sample_in    = d;
    acc = v && slave_ready;
    @(posedge clk);
    if (acc) begin
      exp_q.push_back(d);
      n_acc++;
    end
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    @(posedge clk);
    exp_q.delete();
    repeat (n - 1) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic stream(input int n, input logic [63:0] base);
    int i;
    int budget;
    i = 0;
    budget = 0;
    while (i < n && budget < 20000) begin
      if (slave_ready) begin
        cyc(1'b1, base + 64'(i));
        i++;
      end else begin
        cyc(1'b0, '0);
      end
      budget++;
    end
    chk("stream_budget", 64'(i), 64'(n));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      cyc(1'b0, '0);
      t++;
    end
    cyc(1'b0, '0);
    chk("drain", 64'(exp_q.size()), 0);
  endtask

  task automatic wait_gap();
    int t;
    t = 0;
    while (dbg_active_phase && t < 1000) begin
      cyc(1'b0, '0);
      t++;
    end
    chk("gap_reached", dbg_active_phase, 0);
  endtask

  logic exp_rdy;

  initial begin
    // Reset held three cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", slave_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", slave_ready, 1);

    // Single split
    cyc(1'b1, 64'h1122334455667788);
    @(posedge clk);
    #1;
    chk("split_p1", port1_data, 32'h11223344);
    chk("split_p2", port2_data, 32'h55667788);
    chk("split_v1", port1_valid, 1);
    chk("split_v2", port2_valid, 1);
    chk("split_mem", dbg_mem_data, 64'h1122334455667788);
    chk("split_idx", dbg_sample_idx, 1);

    // Streaming 0..2047
    do_reset(2);
    stream(2048, 64'd0);
    drain();
    chk("stream_idx", dbg_sample_idx, 2048);

    // Overflow: 20 pushes, only 16 fit while the gap holds output
    do_reset(2);
`ifdef SPLITTER_GAP_EN
    wait_gap();
`endif
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
`ifdef SPLITTER_GAP_EN
      exp_rdy = (i < 16);
`else
      exp_rdy = 1'b1;
`endif
      chk("ovf_ready", slave_ready, exp_rdy);
      cyc(1'b1, 64'hA000 + 64'(i));
    end
`ifdef SPLITTER_GAP_EN
    chk("ovf_acc", 64'(n_acc), 16);
    chk("ovf_full", slave_ready, 0);
`else
    chk("ovf_acc", 64'(n_acc), 20);
`endif
    drain();

    // Reset with samples buffered
    do_reset(2);
`ifdef SPLITTER_GAP_EN
    wait_gap();
`endif
    for (int i = 0; i < 10; i++) cyc(1'b1, 64'hB000 + 64'(i));
    do_reset(3);
    chk("midrst_idx", dbg_sample_idx, 0);
    chk("midrst_ready", slave_ready, 1);
    repeat (20) cyc(1'b0, '0);
    chk("midrst_empty_idx", dbg_sample_idx, 0);

    // Continuous 1000-sample stream
    do_reset(2);
    stream(1000, 64'hC0DE_0000_0000_0000);
    drain();
    chk("cont_idx", dbg_sample_idx, 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
